// File: rtl/mmss_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// mmss_alarm_ctrl
//   Alarm controller for the MM:SS BCD timer. Holds a user-set BCD alarm time,
//   rings for RING_SECONDS clock edges when the running time reaches it, and
//   supports stop and, optionally, snooze. Everything runs on the 1 Hz clock.
//
//   Optional feature macro: ALARM_SNOOZE_EN
//     defined   -> snooze input active, SNOOZE state and its counter are built
//     undefined -> snooze ignored, snoozing tied low
//
// Ports
//   clk_1hz                 in   1 Hz clock shared with the timer digits
//   reset                   in   asynchronous, active-high reset
//   sec_unit/sec_tens       in   current time seconds, BCD
//   min_unit/min_tens       in   current time minutes, BCD
//   arm                     in   level, 1 = alarm enabled
//   set_sec / set_min       in   level, +1 alarm second/minute per edge (IDLE only)
//   stop                    in   level, silences the current ring episode
//   snooze                  in   level, defers the ring (snooze build only)
//   alarm_{sec,min}_{unit,tens} out  alarm-time digits, BCD
//   armed / ringing / snoozing  out  registered state decodes
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mmss_alarm_ctrl #(
  parameter int RING_SECONDS   = 10,
  parameter int SNOOZE_SECONDS = 30
) (
  input  logic       clk_1hz,
  input  logic       reset,
  input  logic [3:0] sec_unit,
  input  logic [3:0] sec_tens,
  input  logic [3:0] min_unit,
  input  logic [3:0] min_tens,
  input  logic       arm,
  input  logic       set_sec,
  input  logic       set_min,
  input  logic       stop,
  input  logic       snooze,
  output logic [3:0] alarm_sec_unit,
  output logic [3:0] alarm_sec_tens,
  output logic [3:0] alarm_min_unit,
  output logic [3:0] alarm_min_tens,
  output logic       armed,
  output logic       ringing,
  output logic       snoozing
);

  localparam int MAX_SECONDS = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
  localparam int CW          = $clog2(MAX_SECONDS + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t RING_LOAD = cnt_t'(RING_SECONDS - 1);

`ifdef ALARM_SNOOZE_EN
  localparam cnt_t SNZ_LOAD = cnt_t'(SNOOZE_SECONDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2
  } state_t;
`endif

  state_t     state, next_state;
  cnt_t       ring_cnt, ring_cnt_next;
  logic [7:0] alarm_sec, alarm_sec_next;   // {tens, unit}
  logic [7:0] alarm_min, alarm_min_next;   // {tens, unit}
  logic       match, match_q, trig;

`ifdef ALARM_SNOOZE_EN
  cnt_t snz_cnt, snz_cnt_next;
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
`endif

  // BCD 00..59 increment with wrap to 00.
  function automatic logic [7:0] bcd_inc_59(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 8'h00;
      else                return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  assign match = ({min_tens, min_unit, sec_tens, sec_unit} == {alarm_min, alarm_sec});
  // Rising edge of match: a time held at the alarm value fires only once.
  assign trig  = match & ~match_q;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    next_state     = state;
    ring_cnt_next  = ring_cnt;
`ifdef ALARM_SNOOZE_EN
    snz_cnt_next   = snz_cnt;
`endif
    alarm_sec_next = alarm_sec;
    alarm_min_next = alarm_min;

    if (state == IDLE) begin
      if (set_sec) alarm_sec_next = bcd_inc_59(alarm_sec);
      if (set_min) alarm_min_next = bcd_inc_59(alarm_min);
    end

    case (state)
      IDLE: begin
        if (arm) next_state = ARMED;
      end
      ARMED: begin
        if (!arm) begin
          next_state = IDLE;
        end else if (trig) begin
          next_state    = RINGING;
          ring_cnt_next = RING_LOAD;
        end
      end
      RINGING: begin
        if (!arm) begin
          next_state = IDLE;
        end else if (stop) begin
          next_state = ARMED;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze) begin
          next_state   = SNOOZE;
          snz_cnt_next = SNZ_LOAD;
`endif
        end else if (ring_cnt == '0) begin
          next_state = ARMED;
        end else begin
          ring_cnt_next = ring_cnt - cnt_t'(1);
        end
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (!arm) begin
          next_state = IDLE;
        end else if (stop) begin
          next_state = ARMED;
        end else if (snz_cnt == '0) begin
          next_state    = RINGING;
          ring_cnt_next = RING_LOAD;
        end else begin
          snz_cnt_next = snz_cnt - cnt_t'(1);
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ring_cnt  <= '0;
      alarm_sec <= 8'h00;
      alarm_min <= 8'h00;
      match_q   <= 1'b0;
      armed     <= 1'b0;
      ringing   <= 1'b0;
    end else begin
      state     <= next_state;
      ring_cnt  <= ring_cnt_next;
      alarm_sec <= alarm_sec_next;
      alarm_min <= alarm_min_next;
      match_q   <= match;
      // Outputs are registered decodes of the state being entered, so they
      // change on the same edge as the state register and never glitch.
      armed     <= (next_state != IDLE);
      ringing   <= (next_state == RINGING);
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk_1hz or posedge reset) begin
    if (reset) begin
      snz_cnt  <= '0;
      snoozing <= 1'b0;
    end else begin
      snz_cnt  <= snz_cnt_next;
      snoozing <= (next_state == SNOOZE);
    end
  end
`else
  assign snoozing = 1'b0;
`endif

  assign alarm_sec_unit = alarm_sec[3:0];
  assign alarm_sec_tens = alarm_sec[7:4];
  assign alarm_min_unit = alarm_min[3:0];
  assign alarm_min_tens = alarm_min[7:4];

endmodule

// File: tb/tb_mmss_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mmss_alarm_ctrl
//   Self-checking bench for mmss_alarm_ctrl. Expected outputs are pushed to a
//   queue as stimulus is applied and popped after the following clock edge.
//   Compared word: {alarm MM:SS (16 bits BCD), armed, ringing, snoozing}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mmss_alarm_ctrl;

  logic       clk_1hz = 1'b0;
  logic       reset   = 1'b1;
  logic [3:0] sec_unit = '0, sec_tens = '0, min_unit = '0, min_tens = '0;
  logic       arm = 1'b0, set_sec = 1'b0, set_min = 1'b0, stop = 1'b0, snooze = 1'b0;
  logic [3:0] alarm_sec_unit, alarm_sec_tens, alarm_min_unit, alarm_min_tens;
  logic       armed, ringing, snoozing;

  mmss_alarm_ctrl #(
    .RING_SECONDS  (10),
    .SNOOZE_SECONDS(30)
  ) dut (
    .clk_1hz       (clk_1hz),
    .reset         (reset),
    .sec_unit      (sec_unit),
    .sec_tens      (sec_tens),
    .min_unit      (min_unit),
    .min_tens      (min_tens),
    .arm           (arm),
    .set_sec       (set_sec),
    .set_min       (set_min),
    .stop          (stop),
    .snooze        (snooze),
    .alarm_sec_unit(alarm_sec_unit),
    .alarm_sec_tens(alarm_sec_tens),
    .alarm_min_unit(alarm_min_unit),
    .alarm_min_tens(alarm_min_tens),
    .armed         (armed),
    .ringing       (ringing),
    .snoozing      (snoozing)
  );

  always #5 clk_1hz = ~clk_1hz;

  logic [18:0] actual;
  assign actual = {alarm_min_tens, alarm_min_unit, alarm_sec_tens, alarm_sec_unit,
                   armed, ringing, snoozing};

  typedef struct {
    string       name;
    logic [18:0] exp;
  } exp_t;

  typedef struct {
    logic        arm;
    logic        set_sec;
    int          m;
    int          s;
    logic [18:0] exp;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[21];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [18:0] exp_out(int m, int s, logic a, logic r, logic z);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), a, r, z};
  endfunction

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got alarm=%h a/r/s=%b expected alarm=%h a/r/s=%b",
               name, act[18:3], act[2:0], exp[18:3], exp[2:0]);
    end
  endtask

  task automatic set_time(input int m, input int s);
    min_tens = 4'(m / 10);
    min_unit = 4'(m % 10);
    sec_tens = 4'(s / 10);
    sec_unit = 4'(s % 10);
  endtask

  // Push the expectation, let one edge pass, then pop and compare.
  task automatic step(input string name, input logic [18:0] e);
    exp_t x;
    exp_q.push_back('{name, e});
    @(posedge clk_1hz);
    #1;
    x = exp_q.pop_front();
    check(x.name, actual, x.exp);
  endtask

  initial begin
    // Table: set alarm to 00:05, arm, then count time 00:01.. and watch a ring.
    for (int i = 0; i < 5; i++) vecs[i] = '{1'b0, 1'b1, 0, 0, exp_out(0, i + 1, 0, 0, 0)};
    vecs[5] = '{1'b1, 1'b0, 0, 0, exp_out(0, 5, 1, 0, 0)};
    for (int i = 6; i < 21; i++)
      vecs[i] = '{1'b1, 1'b0, 0, i - 5, exp_out(0, 5, 1, (i >= 10 && i <= 19), 0)};

    // Reset state
    #2;
    check("reset_state", actual, exp_out(0, 0, 0, 0, 0));
    #2 reset = 1'b0;

    // Alarm setting: seconds wrap, minutes wrap, both together
    set_sec = 1'b1;
    for (int k = 1; k <= 61; k++) step($sformatf("set_sec_%0d", k), exp_out(0, k % 60, 0, 0, 0));
    set_sec = 1'b0;
    set_min = 1'b1;
    for (int k = 1; k <= 63; k++) step($sformatf("set_min_%0d", k), exp_out(k % 60, 1, 0, 0, 0));
    set_sec = 1'b1;
    step("set_both", exp_out(4, 2, 0, 0, 0));
    set_sec = 1'b0;
    set_min = 1'b0;
    arm = 1'b1;
    step("arm_idle", exp_out(4, 2, 1, 0, 0));
    set_sec = 1'b1;
    step("set_ignored_1", exp_out(4, 2, 1, 0, 0));
    step("set_ignored_2", exp_out(4, 2, 1, 0, 0));
    set_sec = 1'b0;

    // Asynchronous reset while armed clears outputs immediately
    reset = 1'b1;
    arm   = 1'b0;
    #1;
    check("reset_async_armed", actual, exp_out(0, 0, 0, 0, 0));
    #2 reset = 1'b0;

    // Table-driven ring episode
    for (int i = 0; i < 21; i++) begin
      arm     = vecs[i].arm;
      set_sec = vecs[i].set_sec;
      set_time(vecs[i].m, vecs[i].s);
      step($sformatf("vec_%0d", i), vecs[i].exp);
    end
    set_sec = 1'b0;

    // Stop on the 3rd ringing edge; time frozen at the match value
    set_time(0, 5);
    step("stop_trig", exp_out(0, 5, 1, 1, 0));
    step("stop_ring1", exp_out(0, 5, 1, 1, 0));
    step("stop_ring2", exp_out(0, 5, 1, 1, 0));
    stop = 1'b1;
    step("stop_ring3", exp_out(0, 5, 1, 0, 0));
    stop = 1'b0;
    for (int k = 0; k < 4; k++) step($sformatf("frozen_no_rering_%0d", k), exp_out(0, 5, 1, 0, 0));

    // Snooze on the 2nd ringing edge
    set_time(0, 6);
    step("snz_pre", exp_out(0, 5, 1, 0, 0));
    set_time(0, 5);
    step("snz_trig", exp_out(0, 5, 1, 1, 0));
    step("snz_ring1", exp_out(0, 5, 1, 1, 0));
    snooze = 1'b1;
`ifdef ALARM_SNOOZE_EN
    step("snz_enter", exp_out(0, 5, 1, 0, 1));
    snooze = 1'b0;
    for (int k = 2; k <= 30; k++) step($sformatf("snz_%0d", k), exp_out(0, 5, 1, 0, 1));
    for (int k = 1; k <= 10; k++) step($sformatf("snz_rering_%0d", k), exp_out(0, 5, 1, 1, 0));
    step("snz_done", exp_out(0, 5, 1, 0, 0));
`else
    step("snz_ignored", exp_out(0, 5, 1, 1, 0));
    snooze = 1'b0;
    for (int k = 3; k <= 9; k++) step($sformatf("ring_full_%0d", k), exp_out(0, 5, 1, 1, 0));
    step("ring_full_done", exp_out(0, 5, 1, 0, 0));
`endif

    // Disarm during RINGING
    set_time(0, 6);
    step("disarm_pre", exp_out(0, 5, 1, 0, 0));
    set_time(0, 5);
    step("disarm_trig", exp_out(0, 5, 1, 1, 0));
    arm = 1'b0;
    step("disarm_ringing", exp_out(0, 5, 0, 0, 0));
    arm = 1'b1;
    step("rearm", exp_out(0, 5, 1, 0, 0));
`ifdef ALARM_SNOOZE_EN
    // Disarm during SNOOZE
    set_time(0, 6);
    step("disarm_snz_pre", exp_out(0, 5, 1, 0, 0));
    set_time(0, 5);
    step("disarm_snz_trig", exp_out(0, 5, 1, 1, 0));
    snooze = 1'b1;
    step("disarm_snz_enter", exp_out(0, 5, 1, 0, 1));
    snooze = 1'b0;
    arm = 1'b0;
    step("disarm_snoozing", exp_out(0, 5, 0, 0, 0));
    arm = 1'b1;
    step("rearm_snz", exp_out(0, 5, 1, 0, 0));
`endif

    // Reset pulse mid-ring with arm held high
    set_time(0, 6);
    step("rst_pre", exp_out(0, 5, 1, 0, 0));
    set_time(0, 5);
    step("rst_trig", exp_out(0, 5, 1, 1, 0));
    step("rst_ring1", exp_out(0, 5, 1, 1, 0));
    reset = 1'b1;
    #1;
    check("reset_mid_ring", actual, exp_out(0, 0, 0, 0, 0));
    #2 reset = 1'b0;
    step("armed_after_reset", exp_out(0, 0, 1, 0, 0));

    // Timer reset to 00:00 with alarm 00:00 while armed triggers next edge
    set_time(0, 0);
    step("timer_reset_trig", exp_out(0, 0, 1, 1, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
